// File: rtl/kuznechik_pkg.sv
`default_nettype none
// ============================================================================
// Package : kuznechik_pkg
// Brief   : Shared GOST R 34.12-2015 (Kuznechik) primitives: the pi S-box,
//           l-function coefficients, GF(2^8) multiply (poly 0x1C3), round
//           constants C1..C32 and the key-schedule state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package kuznechik_pkg;

  typedef enum logic [2:0] {
    KS_IDLE  = 3'd0,
    KS_EMIT  = 3'd1,
    KS_XS    = 3'd2,
    KS_LIN   = 3'd3,
    KS_FEIST = 3'd4,
    KS_DONE  = 3'd5
  } ks_state_e;

  // pi substitution, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_PACK = {
    128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
    128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
    128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
    128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
    128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
    128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
    128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
    128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6
  };

  // Entry x sits at bit offset (255-x)*8, and 255-x is simply ~x.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_PACK[{~x, 3'b000} +: 8];
  endfunction

  // Coefficient for byte k, k=0 being bits [127:120].
  function automatic logic [7:0] l_coef(input int k);
    case (k)
      0, 14:   return 8'd148;
      1, 13:   return 8'd32;
      2, 12:   return 8'd133;
      3, 11:   return 8'd16;
      4, 10:   return 8'd194;
      5, 9:    return 8'd192;
      7:       return 8'd251;
      default: return 8'd1;
    endcase
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ s;
      s = s[7] ? ({s[6:0], 1'b0} ^ 8'hC3) : {s[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] l_func(input logic [127:0] v);
    logic [7:0] acc;
    acc = 8'h00;
    for (int k = 0; k < 16; k++) acc = acc ^ gf_mul(l_coef(k), v[127-8*k -: 8]);
    return acc;
  endfunction

  // C_i = L(i) with i in the low byte; C_i occupies bits [(i-1)*128 +: 128].
  function automatic logic [32*128-1:0] gen_c_pack();
    logic [32*128-1:0] r;
    logic [127:0]      v;
    r = '0;
    for (int i = 1; i <= 32; i++) begin
      v = 128'(i);
      for (int s = 0; s < 16; s++) v = {l_func(v), v[127:8]};
      r[(i-1)*128 +: 128] = v;
    end
    return r;
  endfunction

  localparam logic [32*128-1:0] C_PACK = gen_c_pack();

endpackage
`default_nettype wire

// File: rtl/kuznechik_l_step.sv
`default_nettype none
// ============================================================================
// Module  : kuznechik_l_step
// Brief   : Combinational linear function l: 16 bytes -> 1 byte, the feedback
//           byte of one R step. Shared with the cipher datapath.
// Ports   : blk_i [127:0] input block; l_o [7:0] l(blk_i)
// Revision: 1.0 - initial release
// ============================================================================
module kuznechik_l_step
  import kuznechik_pkg::*;
(
  input  logic [127:0] blk_i,
  output logic [7:0]   l_o
);

  logic [7:0] w_term [16];

  for (genvar k = 0; k < 16; k++) begin : g_term
    assign w_term[k] = gf_mul(l_coef(k), blk_i[127-8*k -: 8]);
  end

  always_comb begin
    l_o = 8'h00;
    for (int k = 0; k < 16; k++) l_o = l_o ^ w_term[k];
  end

endmodule
`default_nettype wire

// File: rtl/kuznechik_key_schedule.sv
`default_nettype none
// ============================================================================
// Module  : kuznechik_key_schedule
// Brief   : Expands a 256-bit master key into round keys K1..K10 using 32
//           Feistel iterations (S, then L computed byte-serially over 16
//           cycles) and streams them over a write port.
// Ports   : clk_i, resetn_i (async, active-low), request_i, ack_i,
//           key_i[255:0] -> busy_o, rk_we_o, rk_addr_o[3:0],
//           rk_data_o[127:0], valid_o
// Revision: 1.0 - initial release
// ============================================================================
module kuznechik_key_schedule
  import kuznechik_pkg::*;
#(
  parameter logic [3:0] RK_BASE = 4'd0
) (
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic         request_i,
  input  logic         ack_i,
  input  logic [255:0] key_i,
  output logic         busy_o,
  output logic         rk_we_o,
  output logic [3:0]   rk_addr_o,
  output logic [127:0] rk_data_o,
  output logic         valid_o
);

  ks_state_e    r_state, w_state_d;
  logic [127:0] r_a, r_b, r_t, w_a_d, w_b_d, w_t_d;
  logic [5:0]   r_rnd, w_rnd_d;
  logic [3:0]   r_byte_cnt, w_byte_cnt_d;
  logic         r_phase, w_phase_d;
  logic [2:0]   r_j, w_j_d;
  logic         r_valid, w_valid_d;
  logic         r_we, w_we_d;
  logic [3:0]   r_addr, w_addr_d;
  logic [127:0] r_data, w_data_d;

  logic [127:0] w_xs_in, w_sx;
  logic [7:0]   w_l;
  logic         w_load;

  // Round constant C[rnd+1] lives at slice rnd of the packed table.
  assign w_xs_in = r_a ^ C_PACK[{r_rnd[4:0], 7'd0} +: 128];

  for (genvar k = 0; k < 16; k++) begin : g_sbox
    assign w_sx[8*k +: 8] = sbox(w_xs_in[8*k +: 8]);
  end

  kuznechik_l_step u_l_step (
    .blk_i (r_t),
    .l_o   (w_l)
  );

  assign w_load = request_i && ((r_state == KS_IDLE) || (r_state == KS_DONE));

  always_comb begin
    w_state_d    = r_state;
    w_a_d        = r_a;
    w_b_d        = r_b;
    w_t_d        = r_t;
    w_rnd_d      = r_rnd;
    w_byte_cnt_d = r_byte_cnt;
    w_phase_d    = r_phase;
    w_j_d        = r_j;
    w_valid_d    = r_valid;
    w_we_d       = 1'b0;
    w_addr_d     = r_addr;
    w_data_d     = r_data;

    case (r_state)
      KS_IDLE: begin
        if (request_i) w_state_d = KS_EMIT;
      end
      KS_EMIT: begin
        w_we_d   = 1'b1;
        // {j, phase} is exactly 2j+phase.
        w_addr_d = RK_BASE + {r_j, r_phase};
        w_data_d = r_phase ? r_b : r_a;
        if (!r_phase) begin
          w_phase_d = 1'b1;
        end else begin
          w_phase_d = 1'b0;
          if (r_j == 3'd4) begin
            w_state_d = KS_DONE;
            w_valid_d = 1'b1;
          end else begin
            w_j_d     = r_j + 3'd1;
            w_state_d = KS_XS;
          end
        end
      end
      KS_XS: begin
        w_t_d     = w_sx;
        w_state_d = KS_LIN;
      end
      KS_LIN: begin
        w_t_d        = {w_l, r_t[127:8]};
        w_byte_cnt_d = r_byte_cnt + 4'd1;
        if (r_byte_cnt == 4'd15) begin
          w_byte_cnt_d = 4'd0;
          w_state_d    = KS_FEIST;
        end
      end
      KS_FEIST: begin
        w_a_d     = r_t ^ r_b;
        w_b_d     = r_a;
        w_rnd_d   = r_rnd + 6'd1;
        // Every eighth iteration yields the next key pair.
        w_state_d = (w_rnd_d[2:0] == 3'd0) ? KS_EMIT : KS_XS;
      end
      KS_DONE: begin
        if (request_i) begin
          w_state_d = KS_EMIT;
          w_valid_d = 1'b0;
        end else if (ack_i) begin
          w_state_d = KS_IDLE;
          w_valid_d = 1'b0;
        end
      end
      default: w_state_d = KS_IDLE;
    endcase

    if (w_load) begin
      w_a_d        = key_i[255:128];
      w_b_d        = key_i[127:0];
      w_j_d        = 3'd0;
      w_phase_d    = 1'b0;
      w_rnd_d      = 6'd0;
      w_byte_cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state    <= KS_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_t        <= '0;
      r_rnd      <= '0;
      r_byte_cnt <= '0;
      r_phase    <= 1'b0;
      r_j        <= '0;
      r_valid    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state_d;
      r_a        <= w_a_d;
      r_b        <= w_b_d;
      r_t        <= w_t_d;
      r_rnd      <= w_rnd_d;
      r_byte_cnt <= w_byte_cnt_d;
      r_phase    <= w_phase_d;
      r_j        <= w_j_d;
      r_valid    <= w_valid_d;
      r_we       <= w_we_d;
      r_addr     <= w_addr_d;
      r_data     <= w_data_d;
    end
  end

  assign busy_o    = (r_state != KS_IDLE) && (r_state != KS_DONE);
  assign rk_we_o   = r_we;
  assign rk_addr_o = r_addr;
  assign rk_data_o = r_data;
  assign valid_o   = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_kuznechik_key_schedule.sv
`default_nettype none
// ============================================================================
// Module  : tb_kuznechik_key_schedule
// Brief   : Self-checking bench for kuznechik_key_schedule. Expected round-key
//           writes are queued when a request is issued; a monitor pops and
//           compares on every rk_we_o pulse.
// Revision: 1.0 - initial release
// ============================================================================
module tb_kuznechik_key_schedule;

  localparam logic [3:0] RK_BASE = 4'd0;

  localparam logic [255:0] KEY1 =
    256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam logic [255:0] KEY_ALT =
    256'h0f1e2d3c4b5a69788796a5b4c3d2e1f00112233445566778899aabbccddeeff0;
  localparam logic [1279:0] GOLD = {
    128'h8899aabbccddeeff0011223344556677, 128'hfedcba98765432100123456789abcdef,
    128'hdb31485315694343228d6aef8cc78c44, 128'h3d4553d8e9cfec6815ebadc40a9ffd04,
    128'h57646468c44a5e28d3e59246f429f1ac, 128'hbd079435165c6432b532e82834da581b,
    128'h51e640757e8745de705727265a0098b1, 128'h5a7925017b9fdd3ed72a91a22286f984,
    128'hbb44e25378c73123a5f32f73cdb6e517, 128'h72e9dd7416bcf45b755dbaa88e4a4043
  };

  logic         clk;
  logic         resetn;
  logic         request;
  logic         ack;
  logic [255:0] key;
  logic         busy_o, rk_we_o, valid_o;
  logic [3:0]   rk_addr_o;
  logic [127:0] rk_data_o;

  typedef struct packed {
    logic [3:0]   addr;
    logic [127:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  wr_cnt = 0;

  kuznechik_key_schedule #(.RK_BASE(RK_BASE)) dut (
    .clk_i     (clk),
    .resetn_i  (resetn),
    .request_i (request),
    .ack_i     (ack),
    .key_i     (key),
    .busy_o    (busy_o),
    .rk_we_o   (rk_we_o),
    .rk_addr_o (rk_addr_o),
    .rk_data_o (rk_data_o),
    .valid_o   (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h01C3 << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] tb_L(input logic [127:0] v);
    logic [7:0] coef [16];
    logic [7:0] acc;
    coef = '{8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
             8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1};
    for (int r = 0; r < 16; r++) begin
      acc = 8'h00;
      for (int k = 0; k < 16; k++) acc = acc ^ tb_gmul(coef[k], v[127-8*k -: 8]);
      v = {acc, v[127:8]};
    end
    return v;
  endfunction

  function automatic logic [127:0] tb_S(input logic [127:0] v);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = kuznechik_pkg::sbox(v[8*k +: 8]);
    return r;
  endfunction

  function automatic logic [1279:0] model_keys(input logic [255:0] k);
    logic [127:0]  a, b, t;
    logic [1279:0] r;
    a = k[255:128];
    b = k[127:0];
    r = '0;
    r[1279 -: 128] = a;
    r[1151 -: 128] = b;
    for (int i = 1; i <= 32; i++) begin
      t = tb_L(tb_S(a ^ tb_L(128'(i)))) ^ b;
      b = a;
      a = t;
      if (i % 8 == 0) begin
        r[1279 - 256*(i/8) -: 128]       = a;
        r[1279 - 256*(i/8) - 128 -: 128] = b;
      end
    end
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic push_keys(input logic [1279:0] ks);
    wr_t e;
    for (int i = 0; i < 10; i++) begin
      e.addr = RK_BASE + 4'(i);
      e.data = ks[1279 - 128*i -: 128];
      exp_q.push_back(e);
    end
  endtask

  task automatic issue(input logic [255:0] k, input logic with_ack);
    key     = k;
    request = 1'b1;
    ack     = with_ack;
    @(posedge clk); #1;
    request = 1'b0;
    ack     = 1'b0;
  endtask

  // Counts edges after acceptance until valid_o; optionally injects a request at edge 100.
  task automatic wait_valid(input bit inject);
    int n;
    int bad;
    n   = 0;
    bad = 0;
    while (!valid_o && n < 700) begin
      @(posedge clk); #1;
      n++;
      if (inject && n == 99) begin request = 1'b1; key = KEY_ALT; end
      if (inject && n == 100) begin request = 1'b0; key = KEY1; end
      if (!valid_o && !busy_o) bad++;
    end
    check("valid_latency", 128'(n), 128'd586);
    check("busy_during_run", 128'(bad), 128'd0);
    check("busy_in_done", 128'(busy_o), 128'd0);
  endtask

  task automatic check_quiet(input int wr_expected);
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    check("write_count", 128'(wr_cnt), 128'(wr_expected));
  endtask

  // ---------------- monitor ----------------
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rk_we_o) begin
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0d data=%h", rk_addr_o, rk_data_o);
        end else begin
          e = exp_q.pop_front();
          if (rk_addr_o !== e.addr || rk_data_o !== e.data) begin
            errors++;
            $display("FAIL rk_write got addr=%0d data=%h expected addr=%0d data=%h",
                     rk_addr_o, rk_data_o, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1279:0] zk;
    int            w0;
    resetn  = 1'b0;
    request = 1'b0;
    ack     = 1'b0;
    key     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 128'(busy_o), 128'd0);
    check("reset_valid", 128'(valid_o), 128'd0);
    check("reset_we", 128'(rk_we_o), 128'd0);
    check("reset_addr", 128'(rk_addr_o), 128'd0);
    check("reset_data", rk_data_o, 128'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // GOST vector, latency, and a request ignored while busy.
    push_keys(GOLD);
    issue(KEY1, 1'b0);
    wait_valid(1'b1);
    check_quiet(10);

    // ack only in DONE: valid drops, no writes.
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    check("ack_valid_low", 128'(valid_o), 128'd0);
    check("ack_idle_not_busy", 128'(busy_o), 128'd0);

    // Asynchronous reset mid-LIN at edge 300 aborts the run.
    push_keys(GOLD);
    issue(KEY1, 1'b0);
    repeat (300) @(posedge clk);
    #3;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check("abort_busy", 128'(busy_o), 128'd0);
    check("abort_valid", 128'(valid_o), 128'd0);
    check("abort_we", 128'(rk_we_o), 128'd0);
    check("abort_addr", 128'(rk_addr_o), 128'd0);
    check("abort_data", rk_data_o, 128'd0);
    w0 = wr_cnt;
    check("abort_partial_writes", 128'(w0), 128'd16);
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    check("abort_no_more_writes", 128'(wr_cnt), 128'(w0));
    push_keys(GOLD);
    issue(KEY1, 1'b0);
    wait_valid(1'b0);
    check_quiet(w0 + 10);

    // request+ack together in DONE with an all-zero key: request wins.
    zk = model_keys(256'd0);
    push_keys(zk);
    issue(256'd0, 1'b1);
    check("req_ack_valid_low", 128'(valid_o), 128'd0);
    check("req_ack_busy", 128'(busy_o), 128'd1);
    wait_valid(1'b0);
    check_quiet(w0 + 20);

    // ack only: back to IDLE, nothing written.
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    check("final_ack_valid_low", 128'(valid_o), 128'd0);
    check("final_ack_not_busy", 128'(busy_o), 128'd0);
    check_quiet(w0 + 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
